// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches 32-bit words, resolves jumps and HLT locally,
// and hands datapath ops to the datapath with a one-cycle execute strobe.
module instr_sequencer #(
    parameter int PC_W        = 5,
    parameter int EXEC_CYCLES = 4
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    output logic [PC_W-1:0] pmem_addr,
    output logic            pmem_rd_en,
    input  logic [31:0]     pmem_rdata,
    output logic [31:0]     ir_out,
    output logic            exec_valid,
    input  logic [3:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXECUTE, S_HALT
    } state_t;

    localparam logic [3:0]      EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [4:0]      OP_HLT    = 5'd31;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [31:0]     ir_nxt;
    logic [3:0]      exec_cnt, exec_cnt_nxt;
    logic [15:0]     retired_nxt;
    logic            exec_valid_nxt;
    logic [4:0]      oper;

    // flags = {sign, zero, overflow, carry}
    function automatic logic jump_taken(input logic [4:0] op, input logic [3:0] f);
        logic t;
        t = 1'b0;
        case (op)
            5'd20:   t = 1'b1;
            5'd21:   t = f[0];
            5'd22:   t = ~f[0];
            5'd23:   t = f[3];
            5'd24:   t = ~f[3];
            5'd25:   t = f[2];
            5'd26:   t = ~f[2];
            5'd27:   t = f[1];
            5'd28:   t = ~f[1];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return (op >= 5'd20) && (op <= 5'd28);
    endfunction

    assign oper      = ir_out[31:27];
    assign pmem_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ir_nxt         = ir_out;
        exec_cnt_nxt   = exec_cnt;
        retired_nxt    = retired;
        exec_valid_nxt = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                ir_nxt    = pmem_rdata;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (oper == OP_HLT) begin
                    retired_nxt = retired + 16'd1;
                    state_nxt   = S_HALT;
                end else if (is_jump(oper)) begin
                    pc_nxt      = jump_taken(oper, flags) ? ir_out[PC_W-1:0] : pc + PC_ONE;
                    retired_nxt = retired + 16'd1;
                    state_nxt   = S_FETCH;
                end else begin
                    exec_valid_nxt = 1'b1;
                    exec_cnt_nxt   = '0;
                    state_nxt      = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (exec_cnt == EXEC_LAST) begin
                    pc_nxt       = pc + PC_ONE;
                    retired_nxt  = retired + 16'd1;
                    exec_cnt_nxt = '0;
                    state_nxt    = S_FETCH;
                end else begin
                    exec_cnt_nxt = exec_cnt + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir_out     <= '0;
            exec_valid <= 1'b0;
            pmem_rd_en <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            retired    <= '0;
            exec_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ir_out     <= ir_nxt;
            exec_valid <= exec_valid_nxt;
            pmem_rd_en <= (state_nxt == S_FETCH);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted     <= (state_nxt == S_HALT);
            retired    <= retired_nxt;
            exec_cnt   <= exec_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model driving per-cycle checks,
// plus a second instance built with a single execute cycle.
module tb_instr_sequencer;

    localparam int PC_W = 5;
    localparam int E    = 4;
    localparam int DEPTH = 1 << PC_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            sys_rst, start;
    logic [PC_W-1:0] pmem_addr, pc;
    logic            pmem_rd_en, exec_valid, busy, halted;
    logic [31:0]     pmem_rdata, ir_out;
    logic [3:0]      flags;
    logic [15:0]     retired;

    logic            sys_rst1, start1;
    logic [PC_W-1:0] pmem_addr1, pc1;
    logic            pmem_rd_en1, exec_valid1, busy1, halted1;
    logic [31:0]     pmem_rdata1, ir_out1;
    logic [15:0]     retired1;

    logic [31:0] mem [DEPTH];

    instr_sequencer #(.PC_W(PC_W), .EXEC_CYCLES(E)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start),
        .pmem_addr(pmem_addr), .pmem_rd_en(pmem_rd_en), .pmem_rdata(pmem_rdata),
        .ir_out(ir_out), .exec_valid(exec_valid), .flags(flags), .pc(pc),
        .busy(busy), .halted(halted), .retired(retired)
    );

    instr_sequencer #(.PC_W(PC_W), .EXEC_CYCLES(1)) dut1 (
        .clk(clk), .sys_rst(sys_rst1), .start(start1),
        .pmem_addr(pmem_addr1), .pmem_rd_en(pmem_rd_en1), .pmem_rdata(pmem_rdata1),
        .ir_out(ir_out1), .exec_valid(exec_valid1), .flags(flags), .pc(pc1),
        .busy(busy1), .halted(halted1), .retired(retired1)
    );

    // Program memory with one cycle of read latency
    always @(posedge clk) begin
        if (pmem_rd_en)  pmem_rdata  <= mem[pmem_addr];
        if (pmem_rd_en1) pmem_rdata1 <= mem[pmem_addr1];
    end

    int checks = 0;
    int errors = 0;
    int unsigned retired_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int oper, input int rdst, input int rs1,
                                       input int imm, input int isrc);
        return {5'(oper), 5'(rdst), 5'(rs1), 1'(imm), 16'(isrc)};
    endfunction

    // Odd opcodes 21..27 jump on a set flag, even 22..28 on a clear one.
    function automatic bit taken_m(input int oper, input logic [3:0] f);
        int idx;
        if (oper == 20) return 1'b1;
        if (oper <= 22)      idx = 0;
        else if (oper <= 24) idx = 3;
        else if (oper <= 26) idx = 2;
        else                 idx = 1;
        return f[idx] == ((oper % 2) == 1);
    endfunction

    task automatic fill_hlt();
        for (int i = 0; i < DEPTH; i++) mem[i] = mk(31, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        start   = 1'b0;
        step();
        sys_rst   = 1'b0;
        retired_m = 0;
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_rd_en", pmem_rd_en, 0);
        chk("rst_retired", retired, 0);
        chk("rst_ir_out", ir_out, 0);
    endtask

    // Pulse start, then follow the program one instruction at a time.
    task automatic run(input int max_instr, input bit noise, output bit did_halt);
        int a, op;
        logic [31:0] w;
        a = 0;
        did_halt = 1'b0;
        start = 1'b1;
        step();
        for (int i = 0; i < max_instr; i++) begin
            w  = mem[a];
            op = int'(w[31:27]);
            chk("fetch_rd_en", pmem_rd_en, 1);
            chk("fetch_addr", pmem_addr, a);
            chk("fetch_busy", busy, 1);
            chk("fetch_halted", halted, 0);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            chk("wait_rd_en", pmem_rd_en, 0);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            chk("decode_ir_out", ir_out, w);
            chk("decode_exec_valid", exec_valid, 0);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (op == 31) begin
                start = 1'b0;
                retired_m++;
                did_halt = 1'b1;
                chk("halt_halted", halted, 1);
                chk("halt_busy", busy, 0);
                chk("halt_exec_valid", exec_valid, 0);
                chk("halt_pc", pc, a);
                chk("halt_retired", retired, 16'(retired_m));
                break;
            end else if (op >= 20 && op <= 28) begin
                chk("jump_exec_valid", exec_valid, 0);
                a = taken_m(op, flags) ? int'(w[PC_W-1:0]) : (a + 1) % DEPTH;
                retired_m++;
            end else begin
                for (int k = 0; k < E; k++) begin
                    chk("exec_valid", exec_valid, (k == 0));
                    chk("exec_busy", busy, 1);
                    if (k < E - 1) begin
                        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                        step();
                    end
                end
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
                a = (a + 1) % DEPTH;
                retired_m++;
            end
            chk("next_pc", pc, a);
            chk("retired", retired, 16'(retired_m));
        end
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit h;
        sys_rst = 1'b1; start = 1'b0; flags = 4'b0000;
        sys_rst1 = 1'b1; start1 = 1'b0;
        fill_hlt();
        step();
        do_reset();

        // ADI then HLT, then restart from HALT with retired carried over
        mem[0] = mk(2, 0, 2, 1, 4);
        mem[1] = mk(31, 0, 0, 0, 0);
        run(10, 1'b0, h);
        chk("prog1_halted", h, 1);
        run(10, 1'b0, h);
        chk("restart_halted", h, 1);
        chk("restart_retired", retired, 4);

        // JZ taken with zero flag set, then not taken
        fill_hlt();
        mem[0] = mk(0, 2, 0, 0, 1 << 11);
        mem[1] = mk(25, 0, 0, 0, 5);
        flags = 4'b0100;
        do_reset();
        run(10, 1'b0, h);
        chk("jz_taken_pc", pc, 5);
        flags = 4'b0000;
        do_reset();
        run(10, 1'b0, h);
        chk("jz_not_taken_pc", pc, 2);

        // PC wrap from the top address, and a self-loop that never halts
        fill_hlt();
        mem[0]  = mk(20, 0, 0, 0, 31);
        mem[31] = mk(3, 1, 0, 1, 16'h1234);
        do_reset();
        run(5, 1'b1, h);
        chk("wrap_no_halt", h, 0);
        mem[0] = mk(20, 0, 0, 0, 0);
        do_reset();
        run(6, 1'b1, h);
        chk("selfloop_no_halt", h, 0);
        chk("selfloop_pc", pc, 0);

        // Reset in the second execute cycle, with start held high alongside it
        fill_hlt();
        mem[0] = mk(1, 0, 0, 0, 0);
        do_reset();
        start = 1'b1;
        step();
        step(); step(); step();
        chk("midrst_first_exec", exec_valid, 1);
        step();
        sys_rst = 1'b1;
        step();
        chk("midrst_pc", pc, 0);
        chk("midrst_exec_valid", exec_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_retired", retired, 0);
        chk("midrst_rd_en", pmem_rd_en, 0);
        sys_rst = 1'b0;
        start   = 1'b0;
        step();
        chk("midrst_idle_rd_en", pmem_rd_en, 0);
        chk("midrst_idle_busy", busy, 0);
        retired_m = 0;

        // Randomized programs and flags
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel < 5)
                    mem[i] = mk($urandom_range(0, 19), $urandom_range(0, 31), $urandom_range(0, 31),
                                $urandom_range(0, 1), $urandom_range(0, 65535));
                else if (sel < 9)
                    mem[i] = mk($urandom_range(20, 28), 0, 0, 0, $urandom_range(0, 65535));
                else
                    mem[i] = mk(31, 0, 0, 0, 0);
            end
            flags = 4'($urandom_range(0, 15));
            do_reset();
            run(25, 1'b1, h);
        end

        // Single-cycle execute configuration: three ALU ops then HLT
        fill_hlt();
        mem[0] = mk(0, 1, 2, 0, 0);
        mem[1] = mk(2, 3, 1, 1, 7);
        mem[2] = mk(5, 4, 3, 0, 0);
        sys_rst = 1'b1;
        sys_rst1 = 1'b1;
        step();
        sys_rst1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            chk("e1_rd_en", pmem_rd_en1, (c % 4) == 0);
            chk("e1_exec_valid", exec_valid1, ((c % 4) == 3) && (c < 12));
            step();
        end
        chk("e1_halted", halted1, 1);
        chk("e1_retired", retired1, 4);
        chk("e1_pc", pc1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
